mem_clear_ctrl: RTL and testbench
=================================

Name: mem_clear_ctrl

Overview:
- Hardware sequencer that fills a single-port memory with a programmable value. It does in silicon what a simulation-time zero-fill loop does in a testbench.
- Shares the memory write port between a host requester and its own fill engine; the fill engine has priority while running.
- Sits directly in front of the memory macro; host logic connects only through this block.

Parameters:
- DEPTH, 64, number of memory words; need not be a power of two.
- ADDR_W, 6, address width; must satisfy 2**ADDR_W >= DEPTH.
- DATA_W, 8, memory word width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request a fill pass; sampled only in IDLE
- fill_val  in  DATA_W  fill value; latched on the accepted start
- abort  in  1  terminate a running fill
- host_req  in  1  host requests the memory port this cycle
- host_we  in  1  host write enable (read when 0)
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_gnt  out  1  host owns the memory port this cycle
- busy  out  1  fill pass in progress
- done  out  1  one-cycle pulse when a fill pass completes
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data

Behaviour:
- States:
  - IDLE: host owns the port.
  - FILL: engine writes one word per cycle.
  - DONE: one cycle; raises done, then returns to IDLE.
- Reset (asynchronous, immediate):
  - state=IDLE, ptr=0, fill latch=0, busy=0, done=0.
  - Port outputs follow the IDLE muxing with host_req treated as seen, so mem_we=0 unless the host is writing.
  - A fill interrupted by reset is abandoned and gives no done. Memory contents are undefined and are not restored.
- IDLE port muxing (combinational):
  - host_gnt = host_req.
  - mem_we = host_req & host_we.
  - mem_addr = host_addr, mem_wdata = host_wdata.
- IDLE→FILL when start=1:
  - fill_val is latched and ptr cleared to 0.
  - The host is still granted in the start cycle; start takes effect from the next edge.
- FILL:
  - busy=1, host_gnt=0 regardless of host_req. The host must hold its request and see no grant.
  - mem_we=1, mem_addr=ptr, mem_wdata=latched fill value.
  - ptr increments every cycle.
  - When ptr==DEPTH-1, that write is the last one and the next state is DONE.
- DONE:
  - done=1, busy=0, host_gnt=0, mem_we=0.
  - Next state is IDLE.
- Latency: start high in cycle 0 gives writes in cycles 1..DEPTH, done in cycle DEPTH+1, host grant available in cycle DEPTH+2. Throughput is one word per cycle.
- abort:
  - Has effect only in FILL. In the abort cycle mem_we is forced to 0 and host_gnt stays 0.
  - Next state is IDLE with no done pulse.
  - Words already written keep the fill value.
  - Ignored in IDLE and DONE.
- start while in FILL or DONE: ignored, not queued.
- start and abort high together in FILL: abort wins.
- Wrap-around: ptr never exceeds DEPTH-1. It does not wrap to 0 within a pass, including when DEPTH < 2**ADDR_W.
- Output registering:
  - busy and done are pure state decodes.
  - mem_* outputs are combinational from state, ptr and the host inputs. No registered delay on the host path.

Decomposition:
- Shared package mem_ctrl_pkg holds:
  - state encoding localparams ST_IDLE=2'd0, ST_FILL=2'd1, ST_DONE=2'd2;
  - default DEPTH/ADDR_W/DATA_W constants.
- One natural sub-module, mem_clear_addr_cnt: loadable up-counter with clear, enable and last-address flag (ptr==DEPTH-1).
- The FSM and port mux stay in the top module.

Test Plan:
- Reset with a pass in flight: assert rst in the middle of a fill → busy, done and mem_we all 0 immediately. After release, state is IDLE and host_req=1 gives host_gnt=1 in the same cycle.
- Full fill: DEPTH=64, fill_val=8'hA5, start pulse at cycle 0 → mem_we=1 with addr 0..63 and data A5 in cycles 1..64; done=1 only in cycle 65; busy=1 in cycles 1..64. A memory model reads A5 at every address.
- Host stall: host_req=1, host_we=1, addr=5, data=3C held throughout a fill → host_gnt=0 in cycles 1..65; in cycle 66 host_gnt=1 with mem_addr=5, mem_wdata=3C; the model holds 3C at address 5.
- Abort: abort pulse at cycle 11 → writes to addr 0..9 only, mem_we=0 in cycle 11, no done, IDLE in cycle 12; addr 10..63 unchanged.
- Ignored and simultaneous events:
  - start re-pulsed in cycle 20 → the pass still ends with done in cycle 65 and no second pass.
  - start and abort together in FILL → abort behaviour.
  - start with host_req in IDLE → host granted that cycle.
- Non-power-of-two depth: DEPTH=40, ADDR_W=6 → last write at addr 39, done in cycle 41, no write to addr ≥40.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the memory clear controller: FSM state encoding and
// default geometry of the memory it sits in front of.
package mem_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int DEF_DEPTH  = 64;
  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/mem_clear_addr_cnt.sv
// Fill address pointer: clearable up-counter that stops at DEPTH-1 and flags
// the last address of the pass.
module mem_clear_addr_cnt
  import mem_ctrl_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              en_i,
  output logic [ADDR_W-1:0] cnt_o,
  output logic              last_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d;

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == LAST_ADDR);

  // Holding at the last address keeps the pointer inside the memory even
  // when DEPTH is not a power of two.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !last_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_clear_ctrl.sv
// Memory fill sequencer: writes a latched value to every word of a
// single-port memory, sharing the write port with a host requester.
module mem_clear_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] fill_val,
  input  logic              abort,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              busy,
  output logic              done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata
);

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [DATA_W-1:0] fill_q;
  logic [DATA_W-1:0] fill_d;
  logic [ADDR_W-1:0] ptr;
  logic              ptr_last;
  logic              accept_start;

  assign accept_start = (state_q == ST_IDLE) && start;

  mem_clear_addr_cnt #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_addr_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (accept_start),
    .en_i   (state_q == ST_FILL),
    .cnt_o  (ptr),
    .last_o (ptr_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
    end
  end

  // Abort outranks both the last-word transition and any start seen in FILL.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FILL;
          fill_d  = fill_val;
        end
      end
      ST_FILL: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (ptr_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    host_gnt  = host_req;
    mem_we    = host_req & host_we;
    mem_addr  = host_addr;
    mem_wdata = host_wdata;
    case (state_q)
      ST_FILL: begin
        busy      = 1'b1;
        host_gnt  = 1'b0;
        mem_we    = ~abort;
        mem_addr  = ptr;
        mem_wdata = fill_q;
      end
      ST_DONE: begin
        done      = 1'b1;
        host_gnt  = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = ptr;
        mem_wdata = fill_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_clear_ctrl.sv
// Bench for mem_clear_ctrl: two instances (DEPTH 64 and DEPTH 40) driven by
// shared stimulus and compared against a per-cycle reference schedule.
module tb_mem_clear_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] fill_val;
  logic       abort;
  logic       host_req;
  logic       host_we;
  logic [5:0] host_addr;
  logic [7:0] host_wdata;

  logic       g64, b64, d64, we64;
  logic [5:0] a64;
  logic [7:0] w64;
  logic       g40, b40, d40, we40;
  logic [5:0] a40;
  logic [7:0] w40;

  logic [7:0] mem64 [64];
  logic [7:0] mem40 [64];
  logic [7:0] ref64 [64];
  logic [7:0] ref40 [64];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  mem_clear_ctrl #(.DEPTH(64), .ADDR_W(6), .DATA_W(8)) dut64 (
    .clk(clk), .rst(rst), .start(start), .fill_val(fill_val), .abort(abort),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(g64), .busy(b64), .done(d64),
    .mem_we(we64), .mem_addr(a64), .mem_wdata(w64)
  );

  mem_clear_ctrl #(.DEPTH(40), .ADDR_W(6), .DATA_W(8)) dut40 (
    .clk(clk), .rst(rst), .start(start), .fill_val(fill_val), .abort(abort),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(g40), .busy(b40), .done(d40),
    .mem_we(we40), .mem_addr(a40), .mem_wdata(w40)
  );

  // Memory macros behind each controller
  always @(posedge clk) begin
    if (we64) mem64[a64] <= w64;
    if (we40) mem40[a40] <= w40;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected behaviour at cycle c of a pass started at cycle 0, abort pulsed
  // at cycle A (A beyond the pass means no abort takes effect).
  task automatic check_dut(input bit is40, input int c, input int A, input logic [7:0] fv);
    int         D;
    bit         fill, dn;
    logic       o_g, o_b, o_d, o_we;
    logic [5:0] o_a;
    logic [7:0] o_w;
    string      nm;
    D  = is40 ? 40 : 64;
    nm = $sformatf("%s c%0d", is40 ? "d40" : "d64", c);
    if (is40) begin
      o_g = g40; o_b = b40; o_d = d40; o_we = we40; o_a = a40; o_w = w40;
    end else begin
      o_g = g64; o_b = b64; o_d = d64; o_we = we64; o_a = a64; o_w = w64;
    end
    fill = (c >= 1) && (c <= D) && (c <= A);
    dn   = (c == D + 1) && (A > D);
    chk({nm, " busy"}, 32'(o_b), 32'(fill));
    chk({nm, " done"}, 32'(o_d), 32'(dn));
    if (fill) begin
      chk({nm, " gnt"}, 32'(o_g), 32'd0);
      chk({nm, " we"}, 32'(o_we), 32'(c != A));
      if (c != A) begin
        chk({nm, " addr"}, 32'(o_a), 32'(c - 1));
        chk({nm, " wdata"}, 32'(o_w), 32'(fv));
        if (is40) ref40[c-1] = fv; else ref64[c-1] = fv;
      end
    end else if (dn) begin
      chk({nm, " gnt"}, 32'(o_g), 32'd0);
      chk({nm, " we"}, 32'(o_we), 32'd0);
    end else begin
      chk({nm, " gnt"}, 32'(o_g), 32'(host_req));
      chk({nm, " we"}, 32'(o_we), 32'(host_req & host_we));
      chk({nm, " addr"}, 32'(o_a), 32'(host_addr));
      chk({nm, " wdata"}, 32'(o_w), 32'(host_wdata));
      if (host_req && host_we) begin
        if (is40) ref40[host_addr] = host_wdata; else ref64[host_addr] = host_wdata;
      end
    end
  endtask

  task automatic check_mems(input string tag);
    for (int i = 0; i < 64; i++) begin
      chk($sformatf("%s mem64[%0d]", tag, i), 32'(mem64[i]), 32'(ref64[i]));
      chk($sformatf("%s mem40[%0d]", tag, i), 32'(mem40[i]), 32'(ref40[i]));
    end
  endtask

  task automatic resync_refs();
    for (int i = 0; i < 64; i++) begin
      ref64[i] = mem64[i];
      ref40[i] = mem40[i];
    end
  endtask

  // One pass: start at cycle 0, optional abort at A, optional re-start at rep,
  // start raised together with abort when sa is set, random extra starts
  // while both controllers are still busy when rnd is set.
  task automatic run_pass(input string tag, input logic [7:0] fv, input int A,
                          input int rep, input bit sa, input bit stall, input bit rnd);
    int lim;
    lim = (A < 41) ? A : 41;
    for (int c = 0; c <= 67; c++) begin
      @(negedge clk);
      start    = (c == 0) || (c == rep) || (sa && c == A && A <= 41) ||
                 (rnd && c >= 1 && c <= lim && ($urandom_range(0, 7) == 0));
      fill_val = (c == 0) ? fv : 8'($urandom);
      abort    = (c == A);
      if (stall) begin
        host_req = 1'b1; host_we = 1'b1; host_addr = 6'd5; host_wdata = 8'h3C;
      end else begin
        host_req   = 1'($urandom_range(0, 1));
        host_we    = 1'($urandom_range(0, 1));
        host_addr  = 6'($urandom);
        host_wdata = 8'($urandom);
      end
      #1;
      check_dut(1'b0, c, A, fv);
      check_dut(1'b1, c, A, fv);
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0; host_req = 1'b0; host_we = 1'b0;
    #1;
    check_mems(tag);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; fill_val = 8'h00;
    host_req = 1'b1; host_we = 1'b1; host_addr = 6'd17; host_wdata = 8'h6E;
    #2;
    // Reset state: idle decode, host path straight through
    chk("rst busy64", 32'(b64), 32'd0);
    chk("rst done64", 32'(d64), 32'd0);
    chk("rst gnt64", 32'(g64), 32'd1);
    chk("rst we64", 32'(we64), 32'd1);
    chk("rst addr64", 32'(a64), 32'd17);
    chk("rst wdata40", 32'(w40), 32'h6E);
    chk("rst busy40", 32'(b40), 32'd0);
    host_req = 1'b0; host_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    resync_refs();

    run_pass("full",    8'hA5, 1000, -1, 1'b0, 1'b0, 1'b0);
    run_pass("stall",   8'h81, 1000, -1, 1'b0, 1'b1, 1'b0);
    run_pass("abort11", 8'h5A, 11,   -1, 1'b0, 1'b0, 1'b0);
    run_pass("restart", 8'hC3, 1000, 20, 1'b0, 1'b0, 1'b0);
    run_pass("sa_abort", 8'h3E, 25,  -1, 1'b1, 1'b0, 1'b0);
    run_pass("abort41", 8'h99, 41,   -1, 1'b1, 1'b0, 1'b0);
    for (int p = 0; p < 4; p++) begin
      run_pass($sformatf("rand%0d", p), 8'($urandom), int'($urandom_range(1, 70)),
               -1, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
    end

    // Asynchronous reset in the middle of a fill
    @(negedge clk);
    start = 1'b1; fill_val = 8'h5A; host_req = 1'b0; host_we = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2;
    chk("midfill busy64", 32'(b64), 32'd1);
    chk("midfill we40", 32'(we40), 32'd1);
    host_req = 1'b1;
    rst = 1'b1;
    #1;
    chk("arst busy64", 32'(b64), 32'd0);
    chk("arst done64", 32'(d64), 32'd0);
    chk("arst we64", 32'(we64), 32'd0);
    chk("arst busy40", 32'(b40), 32'd0);
    chk("arst we40", 32'(we40), 32'd0);
    chk("arst gnt64", 32'(g64), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post gnt64", 32'(g64), 32'd1);
    chk("post gnt40", 32'(g40), 32'd1);
    host_req = 1'b0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post c%0d done64", c), 32'(d64), 32'd0);
      chk($sformatf("post c%0d busy40", c), 32'(b40), 32'd0);
    end
    resync_refs();
    run_pass("after_rst", 8'h0F, 1000, -1, 1'b0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
